// File: rtl/vm_pkg.sv
// Types and constants shared by the coin acceptor and the vending FSM.
package vm_pkg;

    localparam logic [2:0] COIN_NONE = 3'd0;
    localparam logic [2:0] COIN_ONE  = 3'd1;
    localparam logic [2:0] COIN_TWO  = 3'd2;
    localparam logic [2:0] COIN_FIVE = 3'd5;

    typedef enum logic [2:0] {
        WAIT_LOW,
        IDLE,
        MEASURE,
        CLASSIFY,
        STUCK
    } acc_state_t;

endpackage

// File: rtl/coin_debounce.sv
// Two-flop synchroniser plus debouncer for the coin sensor; emits the debounced
// level, one-cycle rise/fall pulses, and a flag saying the input has settled low.
module coin_debounce #(
    parameter int DB_CYC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sense,
    output logic level,
    output logic rise,
    output logic fall,
    output logic settled_low
);
    localparam int DB_W = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;

    logic            sync1, sync2;
    logic [1:0]      primed;
    logic [DB_W-1:0] db_cnt;

    // primed marks when sync2 holds a real sample rather than its reset value
    assign settled_low = primed[1] && !sync2 && !level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            primed <= '0;
            db_cnt <= '0;
            level  <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync1  <= sense;
            sync2  <= sync1;
            primed <= {primed[0], 1'b1};
            rise   <= 1'b0;
            fall   <= 1'b0;
            if (sync2 == level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_W'(DB_CYC - 1)) begin
                db_cnt <= '0;
                level  <= sync2;
                rise   <= sync2;
                fall   <= !sync2;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor: measures debounced sensor pulse width, classifies the coin and
// presents it downstream with a VLD/ACK handshake; bad or surplus coins are rejected.
module coin_acceptor
    import vm_pkg::*;
#(
    parameter int DB_CYC    = 4,
    parameter int CNT_W     = 11,
    parameter int MAX_PULSE = 1023,
    parameter int W1_MIN    = 100,
    parameter int W1_MAX    = 199,
    parameter int W2_MIN    = 200,
    parameter int W2_MAX    = 299,
    parameter int W5_MIN    = 500,
    parameter int W5_MAX    = 699,
    parameter int REJ_CYC   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       coin_sense,
    output logic [2:0] coin,
    output logic       coin_vld,
    input  logic       coin_ack,
    output logic       reject,
    output logic       fault,
    output logic [7:0] coin_cnt
);
    localparam int RJ_W = $clog2(REJ_CYC + 1);

    acc_state_t       state;
    logic [CNT_W-1:0] width;
    logic [RJ_W-1:0]  rej_cnt;
    logic             level, rise, fall, settled_low;
    logic [2:0]       cls_code;
    logic             take, rej_evt;

    coin_debounce #(.DB_CYC(DB_CYC)) u_db (
        .clk         (clk),
        .rst_n       (rst_n),
        .sense       (coin_sense),
        .level       (level),
        .rise        (rise),
        .fall        (fall),
        .settled_low (settled_low)
    );

    always_comb begin
        cls_code = COIN_NONE;
        if (width >= CNT_W'(W1_MIN) && width <= CNT_W'(W1_MAX))      cls_code = COIN_ONE;
        else if (width >= CNT_W'(W2_MIN) && width <= CNT_W'(W2_MAX)) cls_code = COIN_TWO;
        else if (width >= CNT_W'(W5_MIN) && width <= CNT_W'(W5_MAX)) cls_code = COIN_FIVE;
    end

    assign take    = coin_vld && coin_ack;
    // Stuck sensor, out-of-window width, or a valid coin arriving while one is still pending
    assign rej_evt = (state == MEASURE && !fall && width == CNT_W'(MAX_PULSE)) ||
                     (state == CLASSIFY && (cls_code == COIN_NONE || (coin_vld && !take)));
    assign reject  = (rej_cnt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT_LOW;
            width <= '0;
            fault <= 1'b0;
        end else begin
            case (state)
                WAIT_LOW: if (settled_low) state <= IDLE;
                IDLE: if (rise) begin
                    state <= MEASURE;
                    width <= '0;
                end
                MEASURE: begin
                    if (fall) begin
                        state <= CLASSIFY;
                    end else if (width == CNT_W'(MAX_PULSE)) begin
                        state <= STUCK;
                        fault <= 1'b1;
                    end else begin
                        width <= width + 1'b1;
                    end
                end
                CLASSIFY: state <= IDLE;
                STUCK: if (fall) begin
                    fault <= 1'b0;
                    state <= IDLE;
                end
                default: state <= WAIT_LOW;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coin     <= COIN_NONE;
            coin_vld <= 1'b0;
            coin_cnt <= '0;
            rej_cnt  <= '0;
        end else begin
            if (state == CLASSIFY && cls_code != COIN_NONE && (!coin_vld || take)) begin
                coin     <= cls_code;
                coin_vld <= 1'b1;
            end else if (take) begin
                coin     <= COIN_NONE;
                coin_vld <= 1'b0;
            end
            if (take) coin_cnt <= coin_cnt + 1'b1;
            if (rej_evt)           rej_cnt <= RJ_W'(REJ_CYC);
            else if (rej_cnt != '0) rej_cnt <= rej_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor: table of pulse vectors plus hand-written
// sequences for pending-coin, stuck-sensor and reset corner cases.
module tb_coin_acceptor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       coin_sense = 1'b0;
    logic       coin_ack = 1'b0;
    logic [2:0] coin;
    logic       coin_vld, reject, fault;
    logic [7:0] coin_cnt;

    int checks = 0;
    int failures = 0;
    int rej_cycles = 0;
    int vld_cycles = 0;
    int exp_cnt = 0;
    logic vld_q = 1'b0;
    logic [2:0] exp_q[$];

    typedef struct {
        int         width;
        int         ack_dly;
        logic [2:0] code;
        int         rej;
    } vec_t;

    coin_acceptor dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .coin_sense (coin_sense),
        .coin       (coin),
        .coin_vld   (coin_vld),
        .coin_ack   (coin_ack),
        .reject     (reject),
        .fault      (fault),
        .coin_cnt   (coin_cnt)
    );

    always #5 clk = ~clk;

    // Monitor: count REJECT/VLD cycles and score each newly presented coin
    always @(negedge clk) begin
        if (reject)   rej_cycles = rej_cycles + 1;
        if (coin_vld) vld_cycles = vld_cycles + 1;
        if (coin_vld && !vld_q) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                failures = failures + 1;
                $display("FAIL unexpected_coin: got coin=%0d, required no coin", coin);
            end else begin
                logic [2:0] e;
                e = exp_q.pop_front();
                if (coin !== e) begin
                    failures = failures + 1;
                    $display("FAIL coin_code: got %0d, required %0d", coin, e);
                end
            end
        end
        if (!coin_vld && coin !== 3'd0) begin
            failures = failures + 1;
            $display("FAIL coin_without_vld: got coin=%0d, required 0", coin);
        end
        vld_q = coin_vld;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic pulse(input int w);
        coin_sense = 1'b1;
        repeat (w) step();
        coin_sense = 1'b0;
    endtask

    task automatic wait_vld(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (coin_vld) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) begin
            checks = checks + 1;
            failures = failures + 1;
            $display("FAIL vld_timeout: got coin_vld=0 after 40 cycles, required 1");
        end
    endtask

    task automatic ack_coin(input int dly);
        repeat (dly) step();
        coin_ack = 1'b1;
        step();
        coin_ack = 1'b0;
        exp_cnt = (exp_cnt + 1) % 256;
    endtask

    task automatic run_vec(input vec_t v);
        bit ok;
        rej_cycles = 0;
        vld_cycles = 0;
        if (v.code != 3'd0) exp_q.push_back(v.code);
        pulse(v.width);
        if (v.code != 3'd0) begin
            wait_vld(ok);
            if (ok) ack_coin(v.ack_dly);
        end
        repeat (30) step();
        chk($sformatf("reject_len_w%0d", v.width), rej_cycles, v.rej);
        chk($sformatf("vld_len_w%0d", v.width), vld_cycles, (v.code != 3'd0) ? v.ack_dly + 1 : 0);
        chk($sformatf("coin_cnt_w%0d", v.width), int'(coin_cnt), exp_cnt);
        chk($sformatf("queue_drained_w%0d", v.width), exp_q.size(), 0);
    endtask

    task automatic do_reset(input logic sense);
        coin_sense = sense;
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        exp_cnt = 0;
    endtask

    vec_t vecs[9];
    bit   ok;

    initial begin
        vecs[0] = '{width: 150, ack_dly: 3, code: 3'd1, rej: 0};
        vecs[1] = '{width: 250, ack_dly: 0, code: 3'd2, rej: 0};
        vecs[2] = '{width: 600, ack_dly: 1, code: 3'd5, rej: 0};
        vecs[3] = '{width: 350, ack_dly: 0, code: 3'd0, rej: 8};
        vecs[4] = '{width: 3,   ack_dly: 0, code: 3'd0, rej: 0};
        vecs[5] = '{width: 180, ack_dly: 2, code: 3'd1, rej: 0};
        vecs[6] = '{width: 650, ack_dly: 0, code: 3'd5, rej: 0};
        vecs[7] = '{width: 50,  ack_dly: 0, code: 3'd0, rej: 8};
        vecs[8] = '{width: 450, ack_dly: 0, code: 3'd0, rej: 8};

        do_reset(1'b0);
        step();
        chk("reset_coin", int'(coin), 0);
        chk("reset_vld", int'(coin_vld), 0);
        chk("reset_reject", int'(reject), 0);
        chk("reset_fault", int'(fault), 0);
        chk("reset_cnt", int'(coin_cnt), 0);
        repeat (10) step();

        foreach (vecs[i]) run_vec(vecs[i]);

        // Pending coin not ACKed: the next valid coin is rejected, the held coin survives
        rej_cycles = 0;
        exp_q.push_back(3'd1);
        pulse(150);
        wait_vld(ok);
        pulse(250);
        repeat (30) step();
        chk("pending_reject_len", rej_cycles, 8);
        chk("pending_coin_held", int'(coin), 1);
        chk("pending_vld_held", int'(coin_vld), 1);
        ack_coin(0);
        step();
        chk("pending_vld_cleared", int'(coin_vld), 0);
        chk("pending_cnt", int'(coin_cnt), exp_cnt);

        // Stuck sensor
        rej_cycles = 0;
        coin_sense = 1'b1;
        repeat (1000) step();
        chk("stuck_fault_early", int'(fault), 0);
        repeat (100) step();
        chk("stuck_fault_set", int'(fault), 1);
        chk("stuck_reject_len", rej_cycles, 8);
        coin_sense = 1'b0;
        repeat (20) step();
        chk("stuck_fault_clear", int'(fault), 0);
        run_vec(vecs[0]);

        // Sensor high across reset release
        rej_cycles = 0;
        vld_cycles = 0;
        do_reset(1'b1);
        repeat (300) step();
        coin_sense = 1'b0;
        repeat (30) step();
        chk("high_at_reset_reject", rej_cycles, 0);
        chk("high_at_reset_vld", vld_cycles, 0);
        chk("high_at_reset_cnt", int'(coin_cnt), 0);
        run_vec(vecs[1]);

        // Reset in the middle of a measurement
        rej_cycles = 0;
        vld_cycles = 0;
        coin_sense = 1'b1;
        repeat (100) step();
        do_reset(1'b1);
        repeat (100) step();
        coin_sense = 1'b0;
        repeat (30) step();
        chk("mid_measure_reset_reject", rej_cycles, 0);
        chk("mid_measure_reset_vld", vld_cycles, 0);
        run_vec(vecs[2]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
